// File: rtl/placement_wirelength_eval_if.sv
// ---------------------------------------------------------------------------
// placement_wirelength_eval_if
// Read-port bundle that the wirelength evaluator shares with the placement
// engine: the edge-list ROM read port and the node-position RAM read port.
// Both memories return data one cycle after the read strobe.
//   edge_re / edge_addr   : edge ROM read strobe and edge index
//   edge_a / edge_b       : node pair of the addressed edge
//   pos_re / pos_addr     : position RAM read strobe and node index
//   pos_x / pos_y         : cell coordinates of the addressed node
// Modports: master = evaluator side, slave = memory side.
// ---------------------------------------------------------------------------
interface placement_wirelength_eval_if #(
    parameter int COORD_W = 8,
    parameter int NODE_W  = 7,
    parameter int EDGE_AW = 7
);
    logic                edge_re;
    logic [EDGE_AW-1:0]  edge_addr;
    logic [NODE_W-1:0]   edge_a;
    logic [NODE_W-1:0]   edge_b;
    logic                pos_re;
    logic [NODE_W-1:0]   pos_addr;
    logic [COORD_W-1:0]  pos_x;
    logic [COORD_W-1:0]  pos_y;

    modport master (
        output edge_re, edge_addr, pos_re, pos_addr,
        input  edge_a, edge_b, pos_x, pos_y
    );

    modport slave (
        input  edge_re, edge_addr, pos_re, pos_addr,
        output edge_a, edge_b, pos_x, pos_y
    );
endinterface

// File: rtl/placement_wirelength_eval.sv
// ---------------------------------------------------------------------------
// placement_wirelength_eval
// Walks an edge list of n_edges node pairs, fetches both node positions and
// accumulates Manhattan routing cost (dx+dy-1), 1-hop cost
// (ceil(dx/2)+ceil(dy/2)-1), the longest edge (dx+dy) and the number of edges
// skipped because a node is unplaced (all-ones coordinate) or off-grid.
// Five cycles per edge: S_EDGE, S_PA, S_PB, S_DIFF, S_ACC.
//
// Optional build macro: PLACE_EVAL_TORUS_EN
//   defined   -> wrap-around distances dx=min(dx,GRID_W-dx), dy=min(dy,GRID_H-dy)
//   undefined -> plain Manhattan distance
//
// Ports
//   clk            clock, rising edge
//   reset_n        asynchronous active-low reset
//   start_i        begin evaluation (sampled only in IDLE)
//   n_edges_i      number of edges, latched on start
//   mem            edge ROM / position RAM read ports (master modport)
//   busy_o         high from first S_EDGE through DONE
//   done_o         one-cycle pulse; results valid from then until next start
//   sum_o          signed sum of (dx+dy-1), wraps modulo 2^SUM_W
//   sum_1hop_o     signed sum of (ceil(dx/2)+ceil(dy/2)-1)
//   max_len_o      max dx+dy over evaluated edges
//   unplaced_cnt_o number of skipped edges
// ---------------------------------------------------------------------------
module placement_wirelength_eval #(
    parameter int GRID_W  = 6,
    parameter int GRID_H  = 6,
    parameter int COORD_W = 8,
    parameter int NODE_W  = 7,
    parameter int EDGE_AW = 7,
    parameter int SUM_W   = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start_i,
    input  logic [EDGE_AW:0]             n_edges_i,
    placement_wirelength_eval_if.master  mem,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [SUM_W-1:0]             sum_o,
    output logic [SUM_W-1:0]             sum_1hop_o,
    output logic [COORD_W:0]             max_len_o,
    output logic [EDGE_AW:0]             unplaced_cnt_o
);
    typedef enum logic [2:0] {
        IDLE, S_EDGE, S_PA, S_PB, S_DIFF, S_ACC, DONE
    } state_t;

    localparam logic [COORD_W-1:0] ALL_ONES = '1;
    localparam logic [COORD_W-1:0] GW       = COORD_W'(GRID_W);
    localparam logic [COORD_W-1:0] GH       = COORD_W'(GRID_H);

    state_t              state_q;
    logic [EDGE_AW:0]    n_q;
    logic [EDGE_AW:0]    i_q;
    logic [NODE_W-1:0]   b_q;
    logic [COORD_W-1:0]  xa_q, ya_q;
    logic [COORD_W-1:0]  dx_q, dy_q;
    logic                invalid_q;
    logic                edge_re_q, pos_re_q, busy_q, done_q;
    logic [SUM_W-1:0]    sum_q, hop_q;
    logic [COORD_W:0]    max_q;
    logic [EDGE_AW:0]    unp_q;

    // Node b coordinates are consumed straight from the RAM output in S_DIFF
    // and only the resulting distances are registered.
    logic [COORD_W-1:0]  dx_d, dy_d;
    logic                invalid_d;

    always_comb begin
        dx_d = (xa_q >= mem.pos_x) ? (xa_q - mem.pos_x) : (mem.pos_x - xa_q);
        dy_d = (ya_q >= mem.pos_y) ? (ya_q - mem.pos_y) : (mem.pos_y - ya_q);
`ifdef PLACE_EVAL_TORUS_EN
        // Only meaningful for on-grid nodes; invalid edges are discarded anyway.
        if ((GW - dx_d) < dx_d) dx_d = GW - dx_d;
        if ((GH - dy_d) < dy_d) dy_d = GH - dy_d;
`endif
        invalid_d = (xa_q == ALL_ONES) || (ya_q == ALL_ONES) ||
                    (mem.pos_x == ALL_ONES) || (mem.pos_y == ALL_ONES) ||
                    (xa_q >= GW) || (mem.pos_x >= GW) ||
                    (ya_q >= GH) || (mem.pos_y >= GH);
    end

    logic [COORD_W:0]  len_w, hx_w, hy_w;
    logic [SUM_W-1:0]  sum_inc, hop_inc;

    always_comb begin
        len_w   = {1'b0, dx_q} + {1'b0, dy_q};
        hx_w    = ({1'b0, dx_q} + (COORD_W+1)'(1)) >> 1;
        hy_w    = ({1'b0, dy_q} + (COORD_W+1)'(1)) >> 1;
        sum_inc = SUM_W'(len_w) - SUM_W'(1);
        hop_inc = SUM_W'(hx_w) + SUM_W'(hy_w) - SUM_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            n_q       <= '0;
            i_q       <= '0;
            b_q       <= '0;
            xa_q      <= '0;
            ya_q      <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            invalid_q <= 1'b0;
            edge_re_q <= 1'b0;
            pos_re_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sum_q     <= '0;
            hop_q     <= '0;
            max_q     <= '0;
            unp_q     <= '0;
        end else begin
            done_q    <= 1'b0;
            edge_re_q <= 1'b0;
            pos_re_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        n_q    <= n_edges_i;
                        i_q    <= '0;
                        sum_q  <= '0;
                        hop_q  <= '0;
                        max_q  <= '0;
                        unp_q  <= '0;
                        busy_q <= 1'b1;
                        if (n_edges_i == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_EDGE;
                            edge_re_q <= 1'b1;
                        end
                    end
                end
                S_EDGE: begin
                    state_q  <= S_PA;
                    pos_re_q <= 1'b1;
                end
                S_PA: begin
                    b_q      <= mem.edge_b;
                    state_q  <= S_PB;
                    pos_re_q <= 1'b1;
                end
                S_PB: begin
                    xa_q    <= mem.pos_x;
                    ya_q    <= mem.pos_y;
                    state_q <= S_DIFF;
                end
                S_DIFF: begin
                    dx_q      <= dx_d;
                    dy_q      <= dy_d;
                    invalid_q <= invalid_d;
                    state_q   <= S_ACC;
                end
                S_ACC: begin
                    if (invalid_q) begin
                        unp_q <= unp_q + 1'b1;
                    end else begin
                        sum_q <= sum_q + sum_inc;
                        hop_q <= hop_q + hop_inc;
                        if (len_w > max_q) max_q <= len_w;
                    end
                    i_q <= i_q + 1'b1;
                    if ((i_q + 1'b1) == n_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q   <= S_EDGE;
                        edge_re_q <= 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The first position read must use node a straight off the edge ROM,
    // since it only becomes valid during S_PA.
    assign mem.edge_re   = edge_re_q;
    assign mem.edge_addr = i_q[EDGE_AW-1:0];
    assign mem.pos_re    = pos_re_q;
    assign mem.pos_addr  = (state_q == S_PA) ? mem.edge_a : b_q;

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign sum_o          = sum_q;
    assign sum_1hop_o     = hop_q;
    assign max_len_o      = max_q;
    assign unplaced_cnt_o = unp_q;
endmodule

// File: tb/tb_placement_wirelength_eval.sv
module tb_placement_wirelength_eval;
    localparam int GW = 6, GH = 6, CW = 8, NW = 7, EAW = 7, SW = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    logic           start = 1'b0;
    logic [EAW:0]   n_edges = '0;
    logic           busy, done;
    logic [SW-1:0]  sum, sum1;
    logic [CW:0]    max_len;
    logic [EAW:0]   unp;

    placement_wirelength_eval_if #(.COORD_W(CW), .NODE_W(NW), .EDGE_AW(EAW)) mif ();

    placement_wirelength_eval #(
        .GRID_W(GW), .GRID_H(GH), .COORD_W(CW), .NODE_W(NW), .EDGE_AW(EAW), .SUM_W(SW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start_i(start), .n_edges_i(n_edges),
        .mem(mif), .busy_o(busy), .done_o(done), .sum_o(sum), .sum_1hop_o(sum1),
        .max_len_o(max_len), .unplaced_cnt_o(unp)
    );

    // Memory contents
    logic [NW-1:0] ea [0:127];
    logic [NW-1:0] eb [0:127];
    logic [CW-1:0] px [0:127];
    logic [CW-1:0] py [0:127];

    // One-cycle-latency read ports
    always @(posedge clk) begin
        if (mif.edge_re) begin
            mif.edge_a <= ea[mif.edge_addr];
            mif.edge_b <= eb[mif.edge_addr];
        end
        if (mif.pos_re) begin
            mif.pos_x <= px[mif.pos_addr];
            mif.pos_y <= py[mif.pos_addr];
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference results of the current run
    logic [SW-1:0] e_sum, e_hop;
    logic [CW:0]   e_max;
    logic [EAW:0]  e_unp;
    bit            hold_chk = 1'b0;

    // Behavioural model: plain integer arithmetic over the edge list
    task automatic model(input int n);
        int s, h, mx, u, a, b, xa, ya, xb, yb, dx, dy;
        s = 0; h = 0; mx = 0; u = 0;
        for (int e = 0; e < n; e++) begin
            a = int'(ea[e]); b = int'(eb[e]);
            xa = int'(px[a]); ya = int'(py[a]); xb = int'(px[b]); yb = int'(py[b]);
            if (xa >= GW || xb >= GW || ya >= GH || yb >= GH) begin
                u++;
            end else begin
                dx = (xa > xb) ? xa - xb : xb - xa;
                dy = (ya > yb) ? ya - yb : yb - ya;
`ifdef PLACE_EVAL_TORUS_EN
                if (GW - dx < dx) dx = GW - dx;
                if (GH - dy < dy) dy = GH - dy;
`endif
                s += dx + dy - 1;
                h += (dx + 1) / 2 + (dy + 1) / 2 - 1;
                if (dx + dy > mx) mx = dx + dy;
            end
        end
        e_sum = SW'(s);
        e_hop = SW'(h);
        e_max = (CW+1)'(mx);
        e_unp = (EAW+1)'(u);
    endtask

    // Compare process: while results are meant to be held, check every cycle
    always @(negedge clk) begin
        if (hold_chk) begin
            chk("hold_sum", 64'(sum), 64'(e_sum));
            chk("hold_sum_1hop", 64'(sum1), 64'(e_hop));
            chk("hold_max_len", 64'(max_len), 64'(e_max));
            chk("hold_unplaced", 64'(unp), 64'(e_unp));
            chk("hold_busy_done", 64'({busy, done}), 64'(0));
        end
    end

    task automatic run(input int n, input bit glitch);
        int k, ner, npr;
        bit seen;
        model(n);
        hold_chk = 1'b0;
        @(negedge clk);
        start = 1'b1;
        n_edges = (EAW+1)'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        n_edges = (EAW+1)'($urandom);
        k = 0; ner = 0; npr = 0; seen = 1'b0;
        while (k <= 5 * n + 10) begin
            @(negedge clk);
            ner += int'(mif.edge_re);
            npr += int'(mif.pos_re);
            // A start pulse mid-run must be ignored
            start = (glitch && k == 7) ? 1'b1 : 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            chk("busy_run", 64'(busy), 64'(1));
            k++;
        end
        start = 1'b0;
        chk("done_seen", 64'(seen), 64'(1));
        if (seen) begin
            chk("latency", 64'(k), 64'(5 * n));
            chk("busy_done", 64'(busy), 64'(1));
            chk("sum", 64'(sum), 64'(e_sum));
            chk("sum_1hop", 64'(sum1), 64'(e_hop));
            chk("max_len", 64'(max_len), 64'(e_max));
            chk("unplaced", 64'(unp), 64'(e_unp));
            chk("edge_re_cnt", 64'(ner), 64'(n));
            chk("pos_re_cnt", 64'(npr), 64'(2 * n));
        end
        $display("run n=%0d: sum=%0d sum_1hop=%0d max_len=%0d unplaced=%0d latency=%0d",
                 n, $signed(sum), $signed(sum1), max_len, unp, k);
        @(posedge clk);
        hold_chk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic set_node(input int id, input int x, input int y);
        px[id] = CW'(x);
        py[id] = CW'(y);
    endtask

    task automatic set_edge(input int e, input int a, input int b);
        ea[e] = NW'(a);
        eb[e] = NW'(b);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, 64'({busy, done, mif.edge_re, mif.pos_re}), 64'(0));
        chk({tag, "_sum"}, 64'(sum), 64'(0));
        chk({tag, "_sum_1hop"}, 64'(sum1), 64'(0));
        chk({tag, "_max_unp"}, 64'({max_len, unp}), 64'(0));
        chk({tag, "_addr"}, 64'({mif.edge_addr, mif.pos_addr}), 64'(0));
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            ea[i] = '0; eb[i] = '0; px[i] = '0; py[i] = '0;
        end
        #2 reset_n = 1'b0;
        #10;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // T1
        set_node(0, 0, 0); set_node(1, 3, 2); set_edge(0, 0, 1);
        run(1, 1'b0);
        chk("T1_sum", 64'(sum), 64'(4));
        chk("T1_sum_1hop", 64'(sum1), 64'(2));
        chk("T1_max_len", 64'(max_len), 64'(5));
        chk("T1_unplaced", 64'(unp), 64'(0));

        // T2
        set_node(2, 1, 1); set_node(3, 1, 2); set_node(4, 2, 2);
        set_node(5, 3, 2); set_node(6, 0, 0); set_node(7, 1, 0);
        set_edge(0, 2, 3); set_edge(1, 4, 5); set_edge(2, 6, 7);
        run(3, 1'b1);
        chk("T2_sum", 64'(sum), 64'(0));
        chk("T2_sum_1hop", 64'(sum1), 64'(0));
        chk("T2_max_len", 64'(max_len), 64'(1));

        // T3
        set_node(8, 1, 1); set_node(9, 255, 0); set_node(10, 5, 5);
        set_edge(0, 8, 9); set_edge(1, 6, 10);
        run(2, 1'b0);
        chk("T3_unplaced", 64'(unp), 64'(1));
`ifdef PLACE_EVAL_TORUS_EN
        chk("T3_sum", 64'(sum), 64'(1));
        chk("T3_sum_1hop", 64'(sum1), 64'(1));
        chk("T3_max_len", 64'(max_len), 64'(2));
`else
        chk("T3_sum", 64'(sum), 64'(9));
        chk("T3_sum_1hop", 64'(sum1), 64'(5));
        chk("T3_max_len", 64'(max_len), 64'(10));
`endif

        // T4
        run(0, 1'b0);
        chk("T4_results", 64'({sum, max_len, unp}), 64'(0));
        chk("T4_sum_1hop", 64'(sum1), 64'(0));

        // T6
        set_node(11, 5, 0); set_edge(0, 6, 11);
        run(1, 1'b0);
`ifdef PLACE_EVAL_TORUS_EN
        chk("T6_sum", 64'(sum), 64'(0));
        chk("T6_max_len", 64'(max_len), 64'(1));
`else
        chk("T6_sum", 64'(sum), 64'(4));
        chk("T6_max_len", 64'(max_len), 64'(5));
`endif

        // Randomised placements and edge lists
        for (int r = 0; r < 25; r++) begin
            int n, u;
            for (int i = 0; i < 128; i++) begin
                u = int'($urandom_range(0, 11));
                px[i] = (u == 0) ? 8'hFF : (u == 1) ? CW'($urandom_range(6, 254)) : CW'($urandom_range(0, 5));
                py[i] = (u == 2) ? 8'hFF : (u == 3) ? CW'($urandom_range(6, 254)) : CW'($urandom_range(0, 5));
            end
            n = int'($urandom_range(0, 20));
            for (int e = 0; e < n; e++) set_edge(e, int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
            run(n, (n >= 2) && (r % 3 == 0));
        end

        // T5: reset during S_PB of edge 2, then rerun uninterrupted
        hold_chk = 1'b0;
        @(negedge clk);
        start = 1'b1;
        n_edges = 4;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (13) @(negedge clk);
        chk("T5_in_pb", 64'({mif.pos_re, busy}), 64'(3));
        reset_n = 1'b0;
        #1;
        chk_all_zero("T5_reset");
        @(negedge clk);
        reset_n = 1'b1;
        run(4, 1'b0);

        hold_chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
